// File: rtl/lisnoc_mp_simple_master.sv
// Hardware initiator for the simple message-passing bus slave.
// Buffers local TX packets whole, writes them out, reads RX packets on irq.
module lisnoc_mp_simple_master #(
    parameter int data_width = 32,
    parameter int max_packet = 16,
    parameter int size_width = 5
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [data_width-1:0] tx_data,
    input  logic                  tx_last,
    input  logic                  tx_valid,
    output logic                  tx_ready,

    output logic [data_width-1:0] rx_data,
    output logic                  rx_last,
    output logic                  rx_valid,
    input  logic                  rx_ready,

    output logic                  err_trunc,

    output logic [5:0]            bus_addr,
    output logic                  bus_we,
    output logic                  bus_en,
    output logic [data_width-1:0] bus_data_out,
    input  logic [data_width-1:0] bus_data_in,
    input  logic                  bus_ack,
    input  logic                  irq
);

    localparam int CW = $clog2(max_packet + 1);
    localparam int IW = (max_packet > 1) ? $clog2(max_packet) : 1;

    typedef enum logic [1:0] {
        FILL,
        READY,
        DROP
    } fill_e;

    typedef enum logic [2:0] {
        IDLE,
        TX_SIZE,
        TX_FLIT,
        RX_SIZE,
        RX_FLIT
    } bus_e;

    fill_e                 fill_q, fill_d;
    bus_e                  bus_q, bus_d;

    logic [CW-1:0]         count_q, count_d;
    logic                  trunc_q, trunc_d;
    logic                  err_q, err_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [size_width-1:0] rem_q, rem_d;

    logic [data_width-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rx_last_q, rx_last_d;

    logic [data_width-1:0] buf_q [max_packet];

    logic                  buf_we;
    logic                  bus_fire;
    logic                  last_idx;
    logic                  tx_done;

    // A bus transaction completes on any edge where request and ack meet.
    assign bus_fire = bus_en & bus_ack;

    // Last buffered flit is the one at count-1.
    assign last_idx = (CW'(idx_q) == (count_q - CW'(1)));

    // Final flit write acked: the buffer can be handed back to the filler.
    assign tx_done  = (bus_q == TX_FLIT) & bus_fire & last_idx;

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_last   = rx_last_q;
    assign err_trunc = err_q;
    assign bus_addr  = 6'd0;

    // Fill side: collect one packet, hold it until sent, drop overflow.
    always_comb begin
        fill_d   = fill_q;
        count_d  = count_q;
        trunc_d  = trunc_q;
        err_d    = 1'b0;
        buf_we   = 1'b0;
        tx_ready = 1'b0;
        unique case (fill_q)
            FILL: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    buf_we  = 1'b1;
                    count_d = count_q + CW'(1);
                    if (tx_last) begin
                        fill_d = READY;
                    end else if (count_q == CW'(max_packet - 1)) begin
                        fill_d  = READY;
                        trunc_d = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            READY: begin
                if (tx_done) begin
                    count_d = '0;
                    trunc_d = 1'b0;
                    fill_d  = trunc_q ? DROP : FILL;
                end
            end
            DROP: begin
                tx_ready = 1'b1;
                if (tx_valid && tx_last) begin
                    fill_d = FILL;
                end
            end
            default: begin
                fill_d = FILL;
            end
        endcase
    end

    // Packet storage; contents are don't-care until count covers them.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[count_q[IW-1:0]] <= tx_data;
        end
    end

    // Bus request decode, from registered state only.
    always_comb begin
        bus_en       = 1'b0;
        bus_we       = 1'b0;
        bus_data_out = '0;
        unique case (bus_q)
            TX_SIZE: begin
                bus_en       = 1'b1;
                bus_we       = 1'b1;
                bus_data_out = data_width'(count_q);
            end
            TX_FLIT: begin
                bus_en       = 1'b1;
                bus_we       = 1'b1;
                bus_data_out = buf_q[idx_q];
            end
            RX_SIZE: begin
                bus_en = 1'b1;
            end
            RX_FLIT: begin
                bus_en = !rx_valid_q;
            end
            default: begin
                bus_en = 1'b0;
            end
        endcase
    end

    // Bus sequencing and the RX output register.
    always_comb begin
        bus_d      = bus_q;
        idx_d      = idx_q;
        rem_d      = rem_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        rx_last_d  = rx_last_q;
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        unique case (bus_q)
            IDLE: begin
                if (fill_q == READY) begin
                    bus_d = TX_SIZE;
                end else if (irq) begin
                    bus_d = RX_SIZE;
                end
            end
            TX_SIZE: begin
                if (bus_fire) begin
                    bus_d = TX_FLIT;
                    idx_d = '0;
                end
            end
            TX_FLIT: begin
                if (bus_fire) begin
                    idx_d = idx_q + IW'(1);
                    if (last_idx) begin
                        bus_d = IDLE;
                    end
                end
            end
            RX_SIZE: begin
                if (bus_fire) begin
                    rem_d = bus_data_in[size_width-1:0];
                    if (bus_data_in[size_width-1:0] == '0) begin
                        bus_d = IDLE;
                    end else begin
                        bus_d = RX_FLIT;
                    end
                end
            end
            RX_FLIT: begin
                if (bus_fire) begin
                    rx_data_d  = bus_data_in;
                    rx_valid_d = 1'b1;
                    rx_last_d  = (rem_q == size_width'(1));
                    rem_d      = rem_q - size_width'(1);
                    if (rem_q == size_width'(1)) begin
                        bus_d = IDLE;
                    end
                end
            end
            default: begin
                bus_d = IDLE;
            end
        endcase
    end

    // State registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q     <= FILL;
            bus_q      <= IDLE;
            count_q    <= '0;
            trunc_q    <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            rem_q      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_last_q  <= 1'b0;
        end else begin
            fill_q     <= fill_d;
            bus_q      <= bus_d;
            count_q    <= count_d;
            trunc_q    <= trunc_d;
            err_q      <= err_d;
            idx_q      <= idx_d;
            rem_q      <= rem_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_last_q  <= rx_last_d;
        end
    end

endmodule

// File: tb/tb_lisnoc_mp_simple_master.sv
// Bench for lisnoc_mp_simple_master: packet-level model of bus writes,
// slave reads and RX flits, checked by one negedge monitor.
module tb_lisnoc_mp_simple_master;

    localparam int DW   = 32;
    localparam int MAXP = 4;
    localparam int SW   = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] tx_data;
    logic          tx_last;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_last;
    logic          rx_valid;
    logic          rx_ready;
    logic          err_trunc;
    logic [5:0]    bus_addr;
    logic          bus_we;
    logic          bus_en;
    logic [DW-1:0] bus_data_out;
    logic [DW-1:0] bus_data_in = '0;
    logic          bus_ack = 1'b0;
    logic          irq;

    always #5 clk = ~clk;

    lisnoc_mp_simple_master #(
        .data_width(DW),
        .max_packet(MAXP),
        .size_width(SW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tx_data(tx_data),
        .tx_last(tx_last),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data(rx_data),
        .rx_last(rx_last),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .err_trunc(err_trunc),
        .bus_addr(bus_addr),
        .bus_we(bus_we),
        .bus_en(bus_en),
        .bus_data_out(bus_data_out),
        .bus_data_in(bus_data_in),
        .bus_ack(bus_ack),
        .irq(irq)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_wr[$];
    logic [31:0] rd_q[$];
    logic [32:0] exp_rx[$];
    int          exp_err = 0;

    int n_wr = 0;
    int n_rd = 0;
    int n_err = 0;
    int ack_delay = 0;
    int wcnt = 0;

    logic [31:0] pd [0:7];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Model: a packet of n flits yields a size word then min(n,MAXP) flits.
    task automatic model_tx(input int n);
        int k;
        k = (n > MAXP) ? MAXP : n;
        exp_wr.push_back(32'(k));
        for (int i = 0; i < k; i++) exp_wr.push_back(pd[i]);
        if (n > MAXP) exp_err++;
    endtask

    // Model: slave returns size (junk above the size field) then flits.
    task automatic model_rx(input int sz);
        rd_q.push_back(32'hABCD_0000 | 32'(sz));
        for (int i = 0; i < sz; i++) begin
            rd_q.push_back(pd[i]);
            exp_rx.push_back({(i == sz - 1), pd[i]});
        end
    endtask

    logic        prev_pend = 1'b0;
    logic        prev_we   = 1'b0;
    logic [31:0] prev_do   = '0;
    logic        prev_rxv  = 1'b0;
    logic        prev_rxr  = 1'b0;
    logic [31:0] prev_rxd  = '0;
    logic        prev_rxl  = 1'b0;
    logic        prev_err  = 1'b0;

    // Slave responder and compare process.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst) begin
            bus_ack   = 1'b0;
            wcnt      = 0;
            prev_pend = 1'b0;
            prev_rxv  = 1'b0;
            prev_err  = 1'b0;
        end else begin
            chk("bus_addr", bus_addr, 0);
            if (!bus_we) chk("data_out_idle", bus_data_out, 0);
            if (prev_pend) begin
                chk("en_hold", bus_en, 1);
                chk("we_hold", bus_we, prev_we);
                chk("do_hold", bus_data_out, prev_do);
            end
            if (prev_rxv && !prev_rxr) begin
                chk("rxv_hold", rx_valid, 1);
                chk("rxd_hold", rx_data, prev_rxd);
                chk("rxl_hold", rx_last, prev_rxl);
            end
            if (err_trunc) begin
                n_err++;
                chk("err_pulse", prev_err, 0);
            end
            bus_ack = 1'b0;
            if (bus_en) begin
                if (wcnt >= ack_delay) begin
                    bus_ack = 1'b1;
                    wcnt = 0;
                    if (bus_we) begin
                        n_wr++;
                        chk("wr_expected", exp_wr.size() != 0, 1);
                        if (exp_wr.size() != 0)
                            chk("wr_data", bus_data_out, exp_wr.pop_front());
                    end else begin
                        n_rd++;
                        chk("rd_expected", rd_q.size() != 0, 1);
                        bus_data_in = (rd_q.size() != 0) ?
                                      rd_q.pop_front() : 32'hDEAD_BEEF;
                    end
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
            if (rx_valid && rx_ready) begin
                chk("rx_expected", exp_rx.size() != 0, 1);
                if (exp_rx.size() != 0) begin
                    e = exp_rx.pop_front();
                    chk("rx_data", rx_data, e[31:0]);
                    chk("rx_last", rx_last, e[32]);
                end
            end
            prev_pend = bus_en && !bus_ack;
            prev_we   = bus_we;
            prev_do   = bus_data_out;
            prev_rxv  = rx_valid;
            prev_rxr  = rx_ready;
            prev_rxd  = rx_data;
            prev_rxl  = rx_last;
            prev_err  = err_trunc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int n);
        int c;
        for (int i = 0; i < n; i++) begin
            tx_valid = 1'b1;
            tx_data  = pd[i];
            tx_last  = (i == n - 1);
            c = 0;
            while (!tx_ready && c < 200) begin
                tick();
                c++;
            end
            chk("tx_accept", c < 200, 1);
            tick();
        end
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    task automatic wait_wr(input int target);
        int c;
        c = 0;
        while (n_wr < target && c < 300) begin
            tick();
            c++;
        end
        chk("wait_wr", n_wr >= target, 1);
    endtask

    task automatic wait_rd(input int target);
        int c;
        c = 0;
        while (n_rd < target && c < 300) begin
            tick();
            c++;
        end
        chk("wait_rd", n_rd >= target, 1);
    endtask

    initial begin
        int wb;
        int rb;
        int bad;
        int c;
        rst      = 1'b1;
        tx_data  = '0;
        tx_last  = 1'b0;
        tx_valid = 1'b0;
        rx_ready = 1'b1;
        irq      = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_bus_en", bus_en, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_last", rx_last, 0);
        chk("rst_err", err_trunc, 0);

        // 1-flit TX
        ack_delay = 0;
        pd[0] = 32'hA5;
        model_tx(1);
        chk("model_1flit_size", exp_wr[0], 32'h1);
        wb = n_wr;
        send_pkt(1);
        bad = 0;
        c = 0;
        while (n_wr < wb + 2 && c < 100) begin
            if (tx_ready) bad++;
            tick();
            c++;
        end
        chk("t1_ready_low", bad, 0);
        chk("t1_writes", n_wr, wb + 2);
        chk("t1_ready_back", tx_ready, 1);
        chk("t1_wr_drained", exp_wr.size(), 0);

        // 3-flit TX with slow acks
        ack_delay = 2;
        pd[0] = 32'hD0; pd[1] = 32'hD1; pd[2] = 32'hD2;
        model_tx(3);
        wb = n_wr;
        send_pkt(3);
        bad = 0;
        c = 0;
        while (n_wr < wb + 4 && c < 100) begin
            if (n_wr > wb && !bus_en) bad++;
            tick();
            c++;
        end
        chk("t2_en_gap", bad, 0);
        repeat (4) tick();
        chk("t2_writes", n_wr, wb + 4);
        chk("t2_wr_drained", exp_wr.size(), 0);

        // RX of 2 flits with a held first flit
        ack_delay = 1;
        rx_ready = 1'b0;
        pd[0] = 32'h11; pd[1] = 32'h22;
        model_rx(2);
        rb = n_rd;
        irq = 1'b1;
        wait_rd(rb + 1);
        irq = 1'b0;
        c = 0;
        while (!rx_valid && c < 100) begin
            tick();
            c++;
        end
        chk("t3_rx_valid", rx_valid, 1);
        wb = n_rd;
        for (int i = 0; i < 3; i++) begin
            chk("t3_hold_data", rx_data, 32'h11);
            chk("t3_hold_last", rx_last, 0);
            tick();
        end
        chk("t3_no_read_hold", n_rd, wb);
        rx_ready = 1'b1;
        c = 0;
        while (exp_rx.size() != 0 && c < 100) begin
            tick();
            c++;
        end
        chk("t3_rx_drained", exp_rx.size(), 0);
        repeat (3) tick();
        chk("t3_idle", bus_en, 0);
        chk("t3_reads", n_rd, rb + 3);
        chk("t3_rx_empty", rx_valid, 0);

        // RX with size 0
        model_rx(0);
        rb = n_rd;
        irq = 1'b1;
        wait_rd(rb + 1);
        irq = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (rx_valid) bad++;
            tick();
        end
        chk("t4_no_rx", bad, 0);
        chk("t4_reads", n_rd, rb + 1);
        chk("t4_idle", bus_en, 0);

        // Truncation: 6 flits into a 4-flit buffer
        ack_delay = 0;
        for (int i = 0; i < 6; i++) pd[i] = 32'h100 + 32'(i);
        model_tx(6);
        chk("model_trunc_len", exp_wr.size(), 5);
        chk("model_trunc_size", exp_wr[0], 32'h4);
        wb = n_wr;
        send_pkt(6);
        wait_wr(wb + 5);
        repeat (4) tick();
        chk("t5_writes", n_wr, wb + 5);
        chk("t5_wr_drained", exp_wr.size(), 0);
        chk("t5_err_count", n_err, 1);
        chk("t5_ready", tx_ready, 1);

        // READY and irq in the same idle cycle: TX first
        pd[0] = 32'h77;
        model_tx(1);
        model_rx(0);
        wb = n_wr;
        rb = n_rd;
        send_pkt(1);
        irq = 1'b1;
        wait_rd(rb + 1);
        irq = 1'b0;
        chk("t6_tx_first", n_wr, wb + 2);
        repeat (3) tick();
        chk("t6_wr_drained", exp_wr.size(), 0);

        // Reset in the middle of TX_FLIT
        ack_delay = 3;
        pd[0] = 32'hE0; pd[1] = 32'hE1; pd[2] = 32'hE2;
        model_tx(3);
        wb = n_wr;
        send_pkt(3);
        wait_wr(wb + 1);
        rst = 1'b1;
        tick();
        chk("t7_en_after_rst", bus_en, 0);
        chk("t7_ready_in_rst", tx_ready, 1);
        rst = 1'b0;
        exp_wr.delete();
        tick();
        chk("t7_ready_after", tx_ready, 1);
        chk("t7_en_idle", bus_en, 0);
        ack_delay = 0;
        pd[0] = 32'h55;
        model_tx(1);
        wb = n_wr;
        send_pkt(1);
        wait_wr(wb + 2);
        repeat (3) tick();
        chk("t7_fresh_pkt", exp_wr.size(), 0);
        chk("t7_writes", n_wr, wb + 2);

        chk("err_total", n_err, exp_err);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
